uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low (asserted when 0).
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_data  output  8  received byte holding register.
REQ-006 SHALL have port rx_valid  output  1  holding register contains an unread byte.
REQ-007 SHALL have port rx_rd_strobe  input  1  one-cycle pulse; consumer has taken rx_data.
REQ-008 SHALL have port rx_overrun  output  1  sticky flag; a byte was dropped because the holding register was full.
REQ-009 SHALL have port rx_frame_err  output  1  sticky flag; a byte was dropped because its stop bit sampled 0.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s) before any use; the flops reset to 1.
REQ-011 SHALL use a 16-bit bit-timing counter that is cleared on every state transition.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: rx_s==0 -> START.
REQ-014 START: when counter reaches CLKS_PER_BIT/2 (integer division), sample rx_s; if 0 -> DATA with bit index 0, else -> IDLE as a glitch with no output change.
REQ-015 DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index]; after index 7 is sampled -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample rx_s; if 1 -> deliver byte (REQ-017..019), -> IDLE; if 0 -> set rx_frame_err, discard byte, -> BREAK.
REQ-017 Deliver with rx_valid==0 or with rx_rd_strobe==1 in the same cycle: rx_data<=shift register and rx_valid<=1 on the next edge.
REQ-018 Deliver with rx_valid==1 and no rx_rd_strobe in the same cycle: rx_data unchanged, rx_valid stays 1, rx_overrun<=1.
REQ-019 rx_rd_strobe with rx_valid==1 and no simultaneous delivery: rx_valid<=0 on the next edge; rx_data holds its value.
REQ-020 rx_rd_strobe with rx_valid==0 SHALL be ignored.
REQ-021 Any rx_rd_strobe SHALL clear rx_overrun and rx_frame_err on the next edge, unless a new overrun or framing event occurs in the same cycle; the new event wins and its flag reads 1.
REQ-022 BREAK: remain until rx_s==1, then -> IDLE; no start is detected while the line is held low.
REQ-023 rx_valid SHALL rise between 9.5 and 10 bit times after the rx falling edge, plus synchronizer latency of 2-3 cycles.
REQ-024 Unused or illegal state encodings SHALL -> IDLE on the next edge.
REQ-025 rx_valid SHALL be held high indefinitely until consumed; it is not a pulse.

Reset
REQ-026 While reset==0 on a clock edge: state<=IDLE, counter<=0, bit index<=0, shift register<=0, rx_data<=0x00, rx_valid<=0, rx_overrun<=0, rx_frame_err<=0, synchronizer<=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no partial delivery; after release, the next falling edge starts a fresh frame.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0xA5 with a valid stop bit -> rx_valid=1 and rx_data=0xA5 with both flags 0; one-cycle rx_rd_strobe -> rx_valid=0 next cycle, rx_data still 0xA5.
REQ-029 Drive rx low for 4 cycles, then high -> no rx_valid; the FSM returns to IDLE; a following 0x3C is then received correctly.
REQ-030 Send 0x55 then 0x3C with no strobe -> rx_data=0x55, rx_valid=1, rx_overrun=1; strobe -> rx_valid=0 and rx_overrun=0.
REQ-031 Send 0x81 with stop bit 0, hold the line low for 3 bit times, then release; then send 0x12 -> rx_frame_err=1 with 0x81 never presented; afterwards rx_data=0x12 and rx_valid=1.
REQ-032 Pulse rx_rd_strobe in exactly the delivery cycle of a second byte 0xF0 while the first byte is still valid -> rx_data=0xF0, rx_valid stays 1, rx_overrun=0.
REQ-033 Assert reset during bit 4 of 0x7E -> all outputs 0 next edge; after release, send 0xC3 -> rx_data=0xC3 with both flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a single-byte holding register and sticky overrun/framing flags.
// Byte appears ~9.5 bit times after the start edge plus 2-3 sync cycles; a full holding register drops new bytes.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_rd_strobe,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam logic [15:0] HALF_C = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] LAST_C = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_e;

   logic        rx_meta_q;
   logic        rx_s_q;
   state_e      state_q;
   logic [15:0] cnt_q;
   logic [2:0]  idx_q;
   logic [7:0]  shift_q;

   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_overrun_q, rx_overrun_d;
   logic        rx_frame_err_q, rx_frame_err_d;

   logic        stop_done;
   logic        stop_good;
   logic        stop_bad;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign stop_done = (state_q == S_STOP) && (cnt_q == LAST_C);
   assign stop_good = stop_done && rx_s_q;
   assign stop_bad  = stop_done && !rx_s_q;

   // Bit-timing counter restarts from zero on every state change.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= 16'd0;
               idx_q <= 3'd0;
               if (!rx_s_q) begin
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (cnt_q == HALF_C) begin
                  cnt_q   <= 16'd0;
                  idx_q   <= 3'd0;
                  state_q <= rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_DATA: begin
               if (cnt_q == LAST_C) begin
                  cnt_q          <= 16'd0;
                  shift_q[idx_q] <= rx_s_q;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_STOP: begin
               if (stop_done) begin
                  cnt_q   <= 16'd0;
                  state_q <= rx_s_q ? S_IDLE : S_BREAK;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_BREAK: begin
               cnt_q <= 16'd0;
               if (rx_s_q) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 16'd0;
               idx_q   <= 3'd0;
            end
         endcase
      end
   end

   // A read in the delivery cycle frees the register for the new byte; new events beat the clear.
   always_comb begin
      rx_data_d      = rx_data_q;
      rx_valid_d     = rx_valid_q;
      rx_overrun_d   = rx_overrun_q;
      rx_frame_err_d = rx_frame_err_q;
      if (rx_rd_strobe) begin
         rx_valid_d     = 1'b0;
         rx_overrun_d   = 1'b0;
         rx_frame_err_d = 1'b0;
      end
      if (stop_good) begin
         if (!rx_valid_q || rx_rd_strobe) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            rx_overrun_d = 1'b1;
         end
      end
      if (stop_bad) begin
         rx_frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_data_q      <= 8'h00;
         rx_valid_q     <= 1'b0;
         rx_overrun_q   <= 1'b0;
         rx_frame_err_q <= 1'b0;
      end else begin
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         rx_overrun_q   <= rx_overrun_d;
         rx_frame_err_q <= rx_frame_err_d;
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_overrun   = rx_overrun_q;
   assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed table, random frames against a byte-level model, timing corners.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_rd_strobe;
   logic       rx_overrun;
   logic       rx_frame_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] m_data;
   logic       m_valid, m_ovr, m_fe;
   logic       saw81 = 1'b0;

   typedef struct {
      logic       is_strobe;
      logic [7:0] d;
      logic       stop;
      logic [7:0] e_data;
      logic       e_valid;
      logic       e_ovr;
      logic       e_fe;
   } vec_t;

   vec_t tbl[8];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_rd_strobe (rx_rd_strobe),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_valid && rx_data == 8'h81) saw81 = 1'b1;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [7:0] ed, input logic ev,
                            input logic eo, input logic ef);
      check({name, ".data"},  rx_data,      ed);
      check({name, ".valid"}, rx_valid,     ev);
      check({name, ".ovr"},   rx_overrun,   eo);
      check({name, ".ferr"},  rx_frame_err, ef);
   endtask

   // Byte-level model: what a consumer should observe after a whole frame or a read.
   task automatic model_frame(input logic [7:0] d, input logic stop);
      if (!stop) m_fe = 1'b1;
      else if (m_valid) m_ovr = 1'b1;
      else begin
         m_data  = d;
         m_valid = 1'b1;
      end
   endtask

   task automatic model_strobe();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_fe    = 1'b0;
   endtask

   // Called at a negedge; drives the first nbits bit periods of a frame.
   task automatic drive_frame(input logic [7:0] d, input logic stop, input int nbits);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         rx = f[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stop, input int hold_bits);
      drive_frame(d, stop, 10);
      if (!stop) repeat (hold_bits * CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic strobe();
      rx_rd_strobe = 1'b1;
      @(negedge clk);
      rx_rd_strobe = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat;
      logic [7:0] rd;
      logic       rs;

      tbl[0] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 8'h55, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 8'h3C, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'h81, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0};

      reset = 1'b0;
      rx = 1'b1;
      rx_rd_strobe = 1'b0;
      repeat (3) @(negedge clk);
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].is_strobe) strobe();
         else send(tbl[i].d, tbl[i].stop, 3);
         check_all($sformatf("tbl%0d", i), tbl[i].e_data, tbl[i].e_valid, tbl[i].e_ovr, tbl[i].e_fe);
      end
      check("never_81", saw81, 1'b0);
      m_data = 8'h12; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;

      // Short low glitch must be rejected, then a normal byte received.
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch.valid", rx_valid, 1'b0);
      send(8'h3C, 1'b1, 0);
      model_frame(8'h3C, 1'b1);
      check_all("after_glitch", m_data, m_valid, m_ovr, m_fe);

      for (int n = 0; n < 40; n++) begin
         rd = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 7) != 0);
         send(rd, rs, int'($urandom_range(1, 3)));
         model_frame(rd, rs);
         check_all($sformatf("rnd%0d", n), m_data, m_valid, m_ovr, m_fe);
         if ($urandom_range(0, 1) == 1) begin
            strobe();
            model_strobe();
            check_all($sformatf("rnd%0d.rd", n), m_data, m_valid, m_ovr, m_fe);
         end
      end

      // Read lands exactly in the delivery cycle of the next byte.
      if (!m_valid) begin
         send(8'h11, 1'b1, 0);
         model_frame(8'h11, 1'b1);
      end
      fork
         drive_frame(8'hF0, 1'b1, 10);
         begin
            repeat (155) @(negedge clk);
            rx_rd_strobe = 1'b1;
            @(negedge clk);
            rx_rd_strobe = 1'b0;
         end
      join
      model_strobe();
      model_frame(8'hF0, 1'b1);
      repeat (4) @(negedge clk);
      check_all("collide", 8'hF0, 1'b1, 1'b0, 1'b0);

      strobe();
      model_strobe();
      lat = 0;
      fork
         drive_frame(8'h66, 1'b1, 10);
         begin
            for (int k = 1; k <= 300; k++) begin
               @(negedge clk);
               if (rx_valid) begin
                  lat = k;
                  break;
               end
            end
         end
      join
      model_frame(8'h66, 1'b1);
      check("latency_in_window", (lat >= 154 && lat <= 163), 1'b1);
      repeat (4) @(negedge clk);
      send(8'h99, 1'b1, 0);
      model_frame(8'h99, 1'b1);
      check_all("pre_reset", m_data, m_valid, m_ovr, m_fe);

      // Reset in the middle of bit 4 of 0x7E.
      drive_frame(8'h7E, 1'b1, 5);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (CPB * 10) @(negedge clk);
      check("midreset.no_partial", rx_valid, 1'b0);
      send(8'hC3, 1'b1, 0);
      check_all("after_reset", 8'hC3, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
